// File: rtl/ram_port_arbiter.sv
// Two-port arbiter (CPU port C, host/debug port H) in front of a single-port data RAM.
// One access per arbitration: ISSUE for one cycle, then WAIT for read data when reading.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned CPU_PRIORITY = 0
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e              state_q;
  logic                own_h_q;
  logic                last_h_q;
  logic [1:0]          cnt_q;
  logic                c_gnt_q, h_gnt_q, c_rvalid_q, h_rvalid_q;
  logic                ram_en_q, ram_we_q, busy_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                pick_h;

  // On a tie H wins only under round-robin and only if C owned the last access.
  always_comb begin
    pick_h = h_req;
    if (c_req && h_req) begin
      pick_h = (CPU_PRIORITY != 0) ? 1'b0 : !last_h_q;
    end
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      own_h_q     <= 1'b0;
      last_h_q    <= 1'b1;
      cnt_q       <= '0;
      c_gnt_q     <= 1'b0;
      h_gnt_q     <= 1'b0;
      c_rvalid_q  <= 1'b0;
      h_rvalid_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      c_gnt_q    <= 1'b0;
      h_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (c_req || h_req) begin
            state_q     <= S_ISSUE;
            own_h_q     <= pick_h;
            ram_en_q    <= 1'b1;
            ram_we_q    <= pick_h ? h_we : c_we;
            ram_addr_q  <= pick_h ? h_addr : c_addr;
            ram_wdata_q <= pick_h ? h_wdata : c_wdata;
            c_gnt_q     <= !pick_h;
            h_gnt_q     <= pick_h;
            busy_q      <= 1'b1;
          end
        end
        S_ISSUE: begin
          last_h_q <= own_h_q;
          if (ram_we_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= 2'(RD_LAT - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            rdata_q    <= ram_rdata;
            c_rvalid_q <= !own_h_q;
            h_rvalid_q <= own_h_q;
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign c_gnt     = c_gnt_q;
  assign h_gnt     = h_gnt_q;
  assign c_rvalid  = c_rvalid_q;
  assign h_rvalid  = h_rvalid_q;
  assign rdata     = rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Table-driven bench: instance 0 is RD_LAT=1 round-robin, instance 1 is RD_LAT=3 CPU-priority.
// Each table row = inputs sampled at one edge and the outputs expected in the following cycle.
module tb_ram_port_arbiter;

  localparam logic [6:0] F_CG = 7'b1000000, F_HG = 7'b0100000, F_CV = 7'b0010000;
  localparam logic [6:0] F_HV = 7'b0001000, F_BUSY = 7'b0000100, F_EN = 7'b0000010;
  localparam logic [6:0] F_WE = 7'b0000001;
  localparam logic [6:0] C_WR = F_CG | F_BUSY | F_EN | F_WE;
  localparam logic [6:0] C_RD = F_CG | F_BUSY | F_EN;
  localparam logic [6:0] H_WR = F_HG | F_BUSY | F_EN | F_WE;
  localparam logic [6:0] H_RD = F_HG | F_BUSY | F_EN;

  typedef struct {
    logic        cr, cw;
    logic [5:0]  ca;
    logic [15:0] cd;
    logic        hr, hw;
    logic [5:0]  ha;
    logic [15:0] hd;
    logic [6:0]  fl;
    logic [15:0] rd;
  } vec_t;

  logic        clk, rst_n;
  logic        c_req [2], c_we [2], h_req [2], h_we [2];
  logic [5:0]  c_addr [2], h_addr [2], ram_addr [2];
  logic [15:0] c_wdata [2], h_wdata [2], ram_wdata [2], ram_rdata [2], rdata [2];
  logic        c_gnt [2], h_gnt [2], c_rvalid [2], h_rvalid [2];
  logic        ram_en [2], ram_we [2], busy [2];
  logic [15:0] mem [2][64];
  logic [15:0] pipe [2][3];
  int          total = 0, passed = 0;
  vec_t        ta[$], tb[$];

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .RD_LAT(1), .CPU_PRIORITY(0)) u_rr (
    .clk_main(clk), .reset(rst_n),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_gnt(c_gnt[0]), .c_rvalid(c_rvalid[0]),
    .h_req(h_req[0]), .h_we(h_we[0]), .h_addr(h_addr[0]), .h_wdata(h_wdata[0]),
    .h_gnt(h_gnt[0]), .h_rvalid(h_rvalid[0]),
    .rdata(rdata[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]), .busy(busy[0]));

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .RD_LAT(3), .CPU_PRIORITY(1)) u_pri (
    .clk_main(clk), .reset(rst_n),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_gnt(c_gnt[1]), .c_rvalid(c_rvalid[1]),
    .h_req(h_req[1]), .h_we(h_we[1]), .h_addr(h_addr[1]), .h_wdata(h_wdata[1]),
    .h_gnt(h_gnt[1]), .h_rvalid(h_rvalid[1]),
    .rdata(rdata[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 64; a++) mem[d][a] = '0;
      for (int s = 0; s < 3; s++) pipe[d][s] = '0;
    end
  end

  // Synchronous RAM models; data appears RD_LAT cycles after the enable cycle.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d] && ram_we[d]) mem[d][ram_addr[d]] <= ram_wdata[d];
      if (ram_en[d] && !ram_we[d]) pipe[d][0] <= mem[d][ram_addr[d]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  function automatic vec_t mk(input logic cr, cw, input logic [5:0] ca, input logic [15:0] cd,
                              input logic hr, hw, input logic [5:0] ha, input logic [15:0] hd,
                              input logic [6:0] fl, input logic [15:0] rd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
    v.fl = fl; v.rd = rd;
    return v;
  endfunction

  function automatic logic [6:0] flags(input int d);
    return {c_gnt[d], h_gnt[d], c_rvalid[d], h_rvalid[d], busy[d], ram_en[d], ram_we[d]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic drive(input int d, input vec_t v);
    c_req[d] = v.cr; c_we[d] = v.cw; c_addr[d] = v.ca; c_wdata[d] = v.cd;
    h_req[d] = v.hr; h_we[d] = v.hw; h_addr[d] = v.ha; h_wdata[d] = v.hd;
  endtask

  task automatic apply(input int d, input vec_t v, input string tag);
    @(negedge clk);
    drive(d, v);
    @(posedge clk);
    #1;
    chk({tag, "_flags"}, 64'(flags(d)), 64'(v.fl));
    chk({tag, "_rdata"}, 64'(rdata[d]), 64'(v.rd));
  endtask

  initial begin
    vec_t z, both_rd, b_both, b_h;
    z = mk(0, 0, 6'h00, 16'h0, 0, 0, 6'h00, 16'h0, 7'b0, 16'h0);
    for (int d = 0; d < 2; d++) drive(d, z);
    rst_n = 1'b0;

    // Write/read-back, H-first on a tie after C, then continuous alternating reads.
    ta.push_back(mk(1, 1, 6'h05, 16'hBEEF, 0, 0, 6'h00, 16'h0000, C_WR,   16'h0000));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, 7'b0,   16'h0000));
    ta.push_back(mk(1, 0, 6'h05, 16'h0000, 0, 0, 6'h00, 16'h0000, C_RD,   16'h0000));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_BUSY, 16'h0000));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_CV,   16'hBEEF));
    ta.push_back(mk(1, 0, 6'h00, 16'h0000, 1, 1, 6'h00, 16'h1234, H_WR,   16'hBEEF));
    ta.push_back(mk(1, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, 7'b0,   16'hBEEF));
    ta.push_back(mk(1, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, C_RD,   16'hBEEF));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_BUSY, 16'hBEEF));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_CV,   16'h1234));
    ta.push_back(mk(1, 1, 6'h0A, 16'hAAAA, 1, 1, 6'h0B, 16'hBBBB, H_WR,   16'h1234));
    ta.push_back(mk(1, 1, 6'h0A, 16'hAAAA, 0, 0, 6'h00, 16'h0000, 7'b0,   16'h1234));
    ta.push_back(mk(1, 1, 6'h0A, 16'hAAAA, 0, 0, 6'h00, 16'h0000, C_WR,   16'h1234));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, 7'b0,   16'h1234));
    both_rd = mk(1, 0, 6'h0A, 16'h0000, 1, 0, 6'h0B, 16'h0000, H_RD, 16'h1234);
    ta.push_back(both_rd);
    both_rd.fl = F_BUSY; ta.push_back(both_rd);
    both_rd.fl = F_HV; both_rd.rd = 16'hBBBB; ta.push_back(both_rd);
    both_rd.fl = C_RD; ta.push_back(both_rd);
    both_rd.fl = F_BUSY; ta.push_back(both_rd);
    both_rd.fl = F_CV; both_rd.rd = 16'hAAAA; ta.push_back(both_rd);
    both_rd.fl = H_RD; ta.push_back(both_rd);
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_BUSY, 16'hAAAA));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_HV,   16'hBBBB));
    ta.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, 7'b0,   16'hBBBB));

    // RD_LAT=3 read of the top address, then C-priority under continuous contention.
    tb.push_back(mk(0, 0, 6'h00, 16'h0000, 1, 1, 6'h3F, 16'h5A5A, H_WR,   16'h0000));
    tb.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, 7'b0,   16'h0000));
    tb.push_back(mk(0, 0, 6'h00, 16'h0000, 1, 0, 6'h3F, 16'h0000, H_RD,   16'h0000));
    for (int i = 0; i < 3; i++)
      tb.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_BUSY, 16'h0000));
    tb.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_HV,   16'h5A5A));
    tb.push_back(mk(1, 1, 6'h01, 16'hC0C0, 0, 0, 6'h00, 16'h0000, C_WR,   16'h5A5A));
    tb.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, 7'b0,   16'h5A5A));
    b_both = mk(1, 0, 6'h01, 16'h0000, 1, 0, 6'h3F, 16'h0000, C_RD, 16'h5A5A);
    tb.push_back(b_both);
    b_both.fl = F_BUSY;
    for (int i = 0; i < 3; i++) tb.push_back(b_both);
    b_both.fl = F_CV; b_both.rd = 16'hC0C0; tb.push_back(b_both);
    b_both.fl = C_RD; tb.push_back(b_both);
    b_h = mk(0, 0, 6'h00, 16'h0000, 1, 0, 6'h3F, 16'h0000, F_BUSY, 16'hC0C0);
    for (int i = 0; i < 3; i++) tb.push_back(b_h);
    b_h.fl = F_CV; tb.push_back(b_h);
    b_h.fl = H_RD; tb.push_back(b_h);
    for (int i = 0; i < 3; i++)
      tb.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_BUSY, 16'hC0C0));
    tb.push_back(mk(0, 0, 6'h00, 16'h0000, 0, 0, 6'h00, 16'h0000, F_HV,   16'h5A5A));

    @(posedge clk); @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_flags%0d", d), 64'(flags(d)), 64'h0);
      chk($sformatf("reset_data%0d", d), {rdata[d], ram_wdata[d], 26'(ram_addr[d])}, 64'h0);
    end
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < ta.size(); i++) apply(0, ta[i], $sformatf("rr%0d", i));

    // Reset in the middle of a read: everything clears at once and the read never returns.
    @(negedge clk); drive(0, mk(1, 0, 6'h0A, 16'h0, 0, 0, 6'h00, 16'h0, 7'b0, 16'h0));
    @(posedge clk); #1;
    chk("abort_issue", 64'(flags(0)), 64'(C_RD));
    @(negedge clk); drive(0, z);
    @(posedge clk); #1;
    chk("abort_wait", 64'(flags(0)), 64'(F_BUSY));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_flags", 64'(flags(0)), 64'h0);
    chk("abort_data", {rdata[0], ram_wdata[0], 26'(ram_addr[0])}, 64'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_quiet%0d", i), 64'(flags(0)), 64'h0);
    end
    @(negedge clk); drive(0, mk(1, 0, 6'h0A, 16'h0, 1, 0, 6'h0B, 16'h0, 7'b0, 16'h0));
    @(posedge clk); #1;
    chk("tie_after_reset", 64'(flags(0)), 64'(C_RD));
    @(negedge clk); drive(0, z);

    for (int i = 0; i < tb.size(); i++) apply(1, tb[i], $sformatf("pri%0d", i));

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
